// File: rtl/parity_tx_serializer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : parity_tx_serializer_if
// Brief    : Parallel-in handshake plus serial-out bundle for the parity
//            transmit serializer. The master drives words in and receives
//            the serial stream; the slave is the serializer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface parity_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              dout;
  logic              dout_valid;
  logic              dout_last;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  dout,
    input  dout_valid,
    input  dout_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output dout,
    output dout_valid,
    output dout_last
  );
endinterface
`default_nettype wire

// File: rtl/parity_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : parity_tx_serializer
// Brief    : Serial parity transmitter. Accepts DATA_W-bit words on a
//            valid/ready handshake, shifts them out LSB-first one bit per
//            clock and appends a parity bit flagged with dout_last.
//            Back-to-back frames are sent without an idle gap.
//            Build option: define PARITY_TX_ODD_EN for odd parity
//            (default build produces even parity).
// Revision : 1.0 - initial release
// ============================================================================
module parity_tx_serializer #(
  parameter int DATA_W = 8
) (
  input wire logic               clk,
  input wire logic               rst,
  parity_tx_serializer_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  shift_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               parity_reg;
  logic               dout_reg;
  logic               dout_valid_reg;
  logic               dout_last_reg;

  logic               ready;
  logic               accept;
  logic               word_parity;

  // Ready depends only on state so upstream never sees a combinational
  // loop through in_valid; the PARITY cycle accepts to allow zero-gap frames.
  assign ready  = (state == S_IDLE) || (state == S_PARITY);
  assign accept = bus.in_valid && ready;

`ifdef PARITY_TX_ODD_EN
  assign word_parity = ~^bus.in_data;
`else
  assign word_parity = ^bus.in_data;
`endif

  assign bus.in_ready   = ready;
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.dout_last  = dout_last_reg;

  // Frame sequencer: loads on accept, shifts data bits, then emits parity.
  // dout always mirrors shift_reg[0] during DATA, so each shift preloads
  // the next bit (shift_reg[1]) into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      parity_reg     <= 1'b0;
      dout_reg       <= 1'b0;
      dout_valid_reg <= 1'b0;
      dout_last_reg  <= 1'b0;
    end else if (accept) begin
      state          <= S_DATA;
      shift_reg      <= bus.in_data;
      bit_cnt        <= '0;
      parity_reg     <= word_parity;
      dout_reg       <= bus.in_data[0];
      dout_valid_reg <= 1'b1;
      dout_last_reg  <= 1'b0;
    end else begin
      case (state)
        S_DATA: begin
          shift_reg <= shift_reg >> 1;
          if (bit_cnt == LAST_CNT) begin
            // Counter holds at its final value; the next accept clears it.
            state         <= S_PARITY;
            dout_reg      <= parity_reg;
            dout_last_reg <= 1'b1;
          end else begin
            bit_cnt  <= bit_cnt + CNT_W'(1);
            dout_reg <= shift_reg[1];
          end
        end
        default: begin
          // IDLE without accept, PARITY without accept, and any illegal
          // encoding all settle in IDLE with the serial outputs quiet.
          state          <= S_IDLE;
          dout_reg       <= 1'b0;
          dout_valid_reg <= 1'b0;
          dout_last_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_parity_tx_serializer
// Brief    : Directed, table-driven bench for parity_tx_serializer with
//            DATA_W=8. Expected parity adapts to PARITY_TX_ODD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_tx_serializer;

`ifdef PARITY_TX_ODD_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  parity_tx_serializer_if #(.DATA_W(8)) bus ();

  parity_tx_serializer #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;     // word to send
    logic [7:0] bits;     // expected serial bits, entry i is emitted i-th
    logic       even_par; // expected parity bit in the even build
    bit         disturb;  // wiggle in_data/in_valid during the frame
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a word; returns one cycle after the accepting edge (bit 0 cycle).
  task automatic launch(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
  endtask

  // Checks the DATA_W data cycles and the parity cycle of one frame.
  task automatic frame_body(input logic [7:0] bits, input logic par,
                            input bit disturb, input bit keep);
    if (!keep) bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("data_valid", bus.dout_valid, 1);
      chk("data_bit",   bus.dout, bits[i]);
      chk("data_last",  bus.dout_last, 0);
      chk("data_ready", bus.in_ready, 0);
      if (disturb) begin
        bus.in_valid = (i % 2 == 0);
        bus.in_data  = 8'($urandom);
      end
      if (i == 7 && !keep) bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("par_valid", bus.dout_valid, 1);
    chk("par_bit",   bus.dout, par);
    chk("par_last",  bus.dout_last, 1);
    chk("par_ready", bus.in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, bus.dout_valid, 0);
    chk({name, "_ready"}, bus.in_ready, 1);
    chk({name, "_dout"},  bus.dout, 0);
    chk({name, "_last"},  bus.dout_last, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{data: 8'hA5, bits: 8'b1010_0101, even_par: 1'b0, disturb: 1'b0};
    vecs[1] = '{data: 8'h07, bits: 8'b0000_0111, even_par: 1'b1, disturb: 1'b0};
    vecs[2] = '{data: 8'h3C, bits: 8'b0011_1100, even_par: 1'b0, disturb: 1'b1};
    vecs[3] = '{data: 8'h00, bits: 8'b0000_0000, even_par: 1'b0, disturb: 1'b0};
    vecs[4] = '{data: 8'hFE, bits: 8'b1111_1110, even_par: 1'b1, disturb: 1'b0};
    vecs[5] = '{data: 8'h5A, bits: 8'b0101_1010, even_par: 1'b0, disturb: 1'b0};

    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Asynchronous reset asserted between clock edges.
    #2 rst = 1'b1;
    #1 chk_idle("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_idle("post_reset");
      @(posedge clk); #1;
    end

    // Table of single frames.
    for (int v = 0; v < 6; v++) begin
      launch(vecs[v].data);
      frame_body(vecs[v].bits, vecs[v].even_par ^ ODD, vecs[v].disturb, 1'b0);
      chk_idle("gap");
    end

    // Back-to-back: in_valid held high, second word waiting at the parity cycle.
    launch(8'hFF);
    bus.in_data = 8'h01;
    frame_body(8'hFF, 1'b0 ^ ODD, 1'b0, 1'b1);
    frame_body(8'h01, 1'b1 ^ ODD, 1'b0, 1'b0);
    chk_idle("b2b_end");

    // Mid-frame abort after bit 3, then restart with in_valid rising with rst release.
    launch(8'hA5);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_pre_valid", bus.dout_valid, 1);
      chk("abort_pre_bit",   bus.dout, 8'hA5 >> i & 8'h01);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #3 rst = 1'b1;
    #1 chk_idle("abort");
    @(posedge clk); #1;
    chk_idle("abort_hold");
    rst = 1'b0;
    launch(8'h80);
    frame_body(8'b1000_0000, 1'b1 ^ ODD, 1'b0, 1'b0);
    chk_idle("restart_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parity_tx_serializer.md
# parity_tx_serializer

- Serial parity transmitter: accepts parallel words on a valid/ready handshake.
- Shifts each word out LSB-first, one bit per clock, then appends one parity bit so the frame's count of ones is even (odd under the configuration macro).
- Sits on the transmit side of a serial link, producing the bit stream that a downstream serial parity checker consumes.
- Supports back-to-back frames with no idle gap.

## Interface
Parameters:
- DATA_W, 8, data bits per frame; legal range 2..64.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a word to send.
- in_data  input  DATA_W  word to send; sampled only on accept.
- in_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; registered.
- dout_valid  output  1  dout carries a frame bit this cycle; registered.
- dout_last  output  1  dout is the parity bit, i.e. the last bit of the frame; registered.

## Operation
- Accept: in_valid && in_ready at a rising edge.
  - On accept, the block loads in_data into a DATA_W shift register.
  - It clears the bit counter.
  - It computes parity = XOR reduction of in_data (inverted when the macro is defined) and stores it in a parity register.
- States:
  - IDLE:
    - Outputs: in_ready=1, dout_valid=0.
    - Transitions: accept → DATA; otherwise stay in IDLE.
  - DATA:
    - Outputs: in_ready=0, dout_valid=1, dout=shift[0], dout_last=0.
    - Each cycle the shift register shifts right and the counter increments.
    - Transitions: when the counter reaches DATA_W-1, go to PARITY.
  - PARITY:
    - Outputs: dout=parity register, dout_valid=1, dout_last=1, in_ready=1.
    - Transitions: accept → DATA (back-to-back frames); otherwise → IDLE.
- in_ready is decoded combinationally from the state (IDLE or PARITY) and does not depend on in_valid.
- Counter width is max(1, $clog2(DATA_W)). It never wraps mid-frame; it is cleared on every accept.
- Changes to in_data or in_valid outside an accept have no effect on a frame in flight.
- In IDLE, dout is held at 0 and dout_last=0.
- Illegal state encodings recover to IDLE on the next edge, with dout_valid=0.

## Timing
- Reset values, applied immediately on rst assertion:
  - state=IDLE, dout=0, dout_valid=0, dout_last=0, in_ready=1.
  - Shift register, counter and parity register are 0.
- Reset mid-frame: the frame is aborted immediately. No parity bit is emitted for it, and the next frame restarts cleanly after rst deasserts.
- Latency: accept at edge N → bit 0 is on dout, with dout_valid=1, during the cycle after edge N.
- Frame length: DATA_W+1 consecutive dout_valid cycles.
  - Data bits occupy cycles 1..DATA_W after the accept; the parity bit occupies cycle DATA_W+1.
- Back-to-back: an accept during the PARITY cycle puts the new frame's bit 0 in the next cycle. dout_valid stays high continuously, so throughput is 1 frame per DATA_W+1 clocks.
- No accept during PARITY: dout_valid=0 on the next cycle.
- in_valid asserted in the same cycle that rst deasserts: accepted at the first edge with rst low.

## Configuration
- Macro PARITY_TX_ODD_EN.
- Undefined (default): even parity. parity bit = ^in_data, so each frame's total count of ones (data plus parity) is even.
- Defined: odd parity. parity bit = ~^in_data, so each frame's total count of ones is odd.
- Framing, latency and handshake are identical in both builds.

## Test plan
All scenarios use DATA_W=8.
- Reset: assert rst mid-cycle → all outputs take reset values asynchronously. After release with in_valid=0: dout_valid=0 and in_ready=1 for 5 cycles.
- Single frame, even parity: send 0xA5 → dout sequence 1,0,1,0,0,1,0,1 then parity 0. dout_last=1 only on bit 9. dout_valid high for exactly 9 cycles starting 1 cycle after accept.
- Odd data count: send 0x07 → bits 1,1,1,0,0,0,0,0 then parity 1.
  - Built with PARITY_TX_ODD_EN: parity 0.
- Back-to-back: hold in_valid=1 with 0xFF then 0x01 → 18 contiguous dout_valid cycles. Parity bits are 0 then 1. in_ready is high only on cycles 9 and 18.
- Mid-frame abort: send 0xA5, assert rst after bit 3 → dout_valid drops immediately and no parity bit appears. A new 0x80 sent after release gives 0,0,0,0,0,0,0,1 then parity 1.
- Input isolation: change in_data and toggle in_valid during a frame of 0x3C → emitted bits stay 0,0,1,1,1,1,0,0 with parity 0.
